// File: rtl/vu_meter_multi_peak_if.sv
// Sample-in / display-out bundle for the multi-channel VU meter.
// The master drives samples and the mode; the slave (meter) drives LEDs and clip flags.
interface vu_meter_multi_peak_if #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 24,
  parameter int NUM_LEDS = 8
);
  logic                         sample_stb_i;
  logic [NUM_CH*SAMPLE_W-1:0]   samples_i;
  logic                         dot_mode_i;
  logic [NUM_CH*NUM_LEDS-1:0]   leds_o;
  logic [NUM_CH-1:0]            clip_o;

  modport master (
    output sample_stb_i, samples_i, dot_mode_i,
    input  leds_o, clip_o
  );

  modport slave (
    input  sample_stb_i, samples_i, dot_mode_i,
    output leds_o, clip_o
  );
endinterface

// File: rtl/vu_meter_multi_peak.sv
// Multi-channel log-scale VU meter: per-channel envelope, LED bar with peak-hold dot, clip flag.
// Envelope and clip update on the strobe edge; LEDs refresh the cycle after a divider tick; no backpressure.
module vu_meter_multi_peak #(
  parameter int NUM_CH          = 2,
  parameter int SAMPLE_W        = 24,
  parameter int NUM_LEDS        = 8,
  parameter int ATTACK_SHIFT    = 0,
  parameter int DECAY_SHIFT     = 11,
  parameter int TH_BASE         = 16,
  parameter int TH_STEP_SHIFT   = 2,
  parameter int HOLD_TICKS      = 25,
  parameter int CLIP_TH         = (1 << (SAMPLE_W - 1)) - 1024,
  parameter int CLIP_HOLD_TICKS = 50,
  parameter int LED_DIV         = 540000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  vu_meter_multi_peak_if.slave bus
);

  localparam int MAG_W   = SAMPLE_W - 1;
  localparam int CNT_W   = $clog2(NUM_LEDS + 1);
  localparam int HOLD_W  = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int CLIPC_W = (CLIP_HOLD_TICKS > 0) ? $clog2(CLIP_HOLD_TICKS + 1) : 1;
  localparam int DIV_W   = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;

  localparam logic [MAG_W-1:0]   CLIP_TH_M = MAG_W'(CLIP_TH);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(LED_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLD_TICKS);
  localparam logic [CLIPC_W-1:0] CLIP_INIT = CLIPC_W'(CLIP_HOLD_TICKS);

  // Full-scale negative has no positive twin, so it saturates to all ones.
  function automatic logic [MAG_W-1:0] mag_of(input logic [SAMPLE_W-1:0] s);
    logic [MAG_W-1:0] lo;
    lo = s[MAG_W-1:0];
    if (!s[SAMPLE_W-1]) return lo;
    if (lo == '0) return '1;
    return ~lo + 1'b1;
  endfunction

  // Thresholds past 32 shift bits are far beyond any sample, so clamp them to unreachable.
  function automatic logic [63:0] th_val(input int k);
    int sh;
    sh = k * TH_STEP_SHIFT;
    if (sh >= 32) return {64{1'b1}};
    return 64'(TH_BASE) << sh;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_of(input logic [MAG_W-1:0] lvl);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      if (64'(lvl) >= th_val(k)) n = n + 1'b1;
    end
    return n;
  endfunction

  // Minimum step of one keeps both attack and release moving until they meet their target.
  function automatic logic [MAG_W-1:0] level_next(input logic [MAG_W-1:0] lvl,
                                                  input logic [MAG_W-1:0] m);
    logic [MAG_W-1:0] step;
    if (m > lvl) begin
      step = (m - lvl) >> ATTACK_SHIFT;
      if (step == '0) step = MAG_W'(1);
      return lvl + step;
    end
    if (lvl != '0) begin
      step = lvl >> DECAY_SHIFT;
      if (step == '0) step = MAG_W'(1);
      return lvl - step;
    end
    return lvl;
  endfunction

  logic [DIV_W-1:0]               div_q, div_d;
  logic                           tick;
  logic [MAG_W-1:0]               mag     [NUM_CH];
  logic [CNT_W-1:0]               cnt     [NUM_CH];
  logic [MAG_W-1:0]               level_q [NUM_CH];
  logic [MAG_W-1:0]               level_d [NUM_CH];
  logic [CNT_W-1:0]               peak_q  [NUM_CH];
  logic [CNT_W-1:0]               peak_d  [NUM_CH];
  logic [HOLD_W-1:0]              hold_q  [NUM_CH];
  logic [HOLD_W-1:0]              hold_d  [NUM_CH];
  logic [CLIPC_W-1:0]             clipc_q [NUM_CH];
  logic [CLIPC_W-1:0]             clipc_d [NUM_CH];
  logic [NUM_CH-1:0]              clip_q, clip_d;
  logic [NUM_CH-1:0][NUM_LEDS-1:0] leds_q, leds_d;

  always_comb begin
    tick   = (div_q == DIV_LAST);
    div_d  = tick ? '0 : div_q + 1'b1;
    clip_d = clip_q;
    leds_d = leds_q;
    for (int c = 0; c < NUM_CH; c++) begin
      mag[c]     = mag_of(bus.samples_i[c*SAMPLE_W +: SAMPLE_W]);
      cnt[c]     = cnt_of(level_q[c]);
      level_d[c] = bus.sample_stb_i ? level_next(level_q[c], mag[c]) : level_q[c];
      peak_d[c]  = peak_q[c];
      hold_d[c]  = hold_q[c];
      clipc_d[c] = clipc_q[c];

      // Display and peak both sample the pre-update level and the current peak register.
      if (tick) begin
        if (cnt[c] >= peak_q[c]) begin
          peak_d[c] = cnt[c];
          hold_d[c] = HOLD_INIT;
        end else if (hold_q[c] != '0) begin
          hold_d[c] = hold_q[c] - 1'b1;
        end else begin
          peak_d[c] = peak_q[c] - 1'b1;
        end
        for (int k = 0; k < NUM_LEDS; k++) begin
          leds_d[c][k] = (!bus.dot_mode_i && (CNT_W'(k) < cnt[c])) ||
                         (CNT_W'(k + 1) == peak_q[c]);
        end
      end

      if (bus.sample_stb_i && (mag[c] >= CLIP_TH_M)) begin
        clip_d[c]  = 1'b1;
        clipc_d[c] = CLIP_INIT;
      end else if (tick && (clipc_q[c] != '0)) begin
        clipc_d[c] = clipc_q[c] - 1'b1;
        if (clipc_q[c] == CLIPC_W'(1)) clip_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q   <= '0;
      level_q <= '{default: '0};
      peak_q  <= '{default: '0};
      hold_q  <= '{default: '0};
      clipc_q <= '{default: '0};
      clip_q  <= '0;
      leds_q  <= '0;
    end else begin
      div_q   <= div_d;
      level_q <= level_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
      clipc_q <= clipc_d;
      clip_q  <= clip_d;
      leds_q  <= leds_d;
    end
  end

  assign bus.leds_o = leds_q;
  assign bus.clip_o = clip_q;

endmodule

// File: doc/vu_meter_multi_peak.md
Name: vu_meter_multi_peak

Overview:
Parametrised multi-channel VU meter with logarithmic LED bars, peak-hold dot and clip indicator per channel. It sits after the I2S capture block in the 27 MHz domain and is driven by its sample-ready strobe with packed signed PCM channels. It generalises the single-channel 6-LED meter:
- channel count and LED count are parameters;
- attack and decay rates are set independently;
- thresholds are geometric;
- it adds bar/dot display modes.

Parameters:
NUM_CH, 2, number of channels (1..8)
SAMPLE_W, 24, signed sample width per channel
NUM_LEDS, 8, LEDs per channel (2..16)
ATTACK_SHIFT, 0, rise rate: level += (mag-level)>>ATTACK_SHIFT
DECAY_SHIFT, 11, fall rate: level -= level>>DECAY_SHIFT
TH_BASE, 16, threshold of LED 0
TH_STEP_SHIFT, 2, TH_k = TH_BASE << (k*TH_STEP_SHIFT); thresholds ≥ 2^SAMPLE_W are unreachable
HOLD_TICKS, 25, ticks the peak dot holds before falling
CLIP_TH, 2^(SAMPLE_W-1)-1024, magnitude at/above which the clip flag sets
CLIP_HOLD_TICKS, 50, ticks the clip flag stays lit after the last clipping sample
LED_DIV, 540000, clk cycles per display tick (~50 Hz at 27 MHz)

Ports:
clk_i  in  1  system clock (27 MHz)
rst_i  in  1  synchronous, active-high reset
sample_stb_i  in  1  one-cycle strobe, samples_i valid
samples_i  in  NUM_CH*SAMPLE_W  packed signed samples, ch c at [c*SAMPLE_W +: SAMPLE_W]
dot_mode_i  in  1  0 = bar+peak dot, 1 = dot only
leds_o  out  NUM_CH*NUM_LEDS  ch c LEDs at [c*NUM_LEDS +: NUM_LEDS], bit 0 = lowest
clip_o  out  NUM_CH  per-channel clip indicator

Behaviour:
- Reset (rst_i high at a clock edge) clears the following. Reset mid-operation discards all state immediately.
  - outputs: leds_o = 0, clip_o = 0;
  - state: all level, peak, hold and clip counters = 0; divider = 0.
- Magnitude: mag = |sample|, with -2^(SAMPLE_W-1) saturating to 2^(SAMPLE_W-1)-1. mag is SAMPLE_W-1 bits unsigned.
- Level update: on sample_stb_i only, per channel, in a register SAMPLE_W-1 bits wide.
  - if mag > level: level += (mag-level) >> ATTACK_SHIFT; if that increment is 0, level += 1.
  - else if level > 0: level -= level >> DECAY_SHIFT; if that decrement is 0, level -= 1. This guarantees decay to exactly 0.
  - no overflow is possible; level never exceeds the maximum mag.
- Tick: free-running divider that counts 0..LED_DIV-1. tick is high for one cycle when the count wraps.
- Bar count: cnt = number of k in [0,NUM_LEDS) with level ≥ TH_k, giving a thermometer 0..NUM_LEDS. It is computed from the registered level, i.e. the pre-update value if a strobe coincides with a tick.
- Peak state per channel: peak 0..NUM_LEDS and hold counter. On tick:
  - if cnt ≥ peak: peak <= cnt, hold <= HOLD_TICKS;
  - else if hold > 0: hold--;
  - else: peak--.
- Display: on tick, leds_o is registered from the cnt/peak values sampled that cycle; it is visible in the cycle after the tick and held between ticks. dot_mode_i is sampled at the tick.
  - bar mode: bits [cnt-1:0] set, plus bit peak-1 when peak > 0.
  - dot mode: only bit peak-1 (when peak > 0).
- Clip flag per channel:
  - on a strobe with mag ≥ CLIP_TH: clip_o <= 1 and clip counter <= CLIP_HOLD_TICKS (next cycle);
  - on tick with no reload: if counter > 0, decrement; when it reaches 0, clip_o <= 0 in the same update;
  - clip reload and tick in the same cycle: the reload wins.
- Channels are fully independent and share only the divider.
- No backpressure: a strobe is accepted every cycle, including back-to-back strobes.

Test Plan:
Bench settings for all scenarios: defaults except LED_DIV=10, DECAY_SHIFT=4, HOLD_TICKS=4, CLIP_HOLD_TICKS=3.
1. Reset mid-run: hold rst_i 2 cycles while leds lit -> leds_o=0, clip_o=0 the cycle after; first tick after release shows 0x00.
2. Ch0 constant 5000, ch1 = 0, strobe every 4 cycles -> after the first tick ch0 leds = 0x1F (5000 ≥ 4096 < 16384), ch1 = 0x00, clip_o = 00.
3. Ch0 = -8388608 on one strobe -> mag = 8388607, level saturates, next tick ch0 = 0xFF, clip_o[0] = 1 one cycle after the strobe; clip_o[0] clears on the 3rd tick with no further clipping.
4. Ch0 full scale then 0 continuously -> peak = 8 held for 4 ticks with the bar falling, then the peak dot steps 7, 6, ... one per tick, never below cnt.
5. Decay floor: level = 3, mag = 0, DECAY_SHIFT = 4 -> level 2, 1, 0 on successive strobes and stays 0.
6. dot_mode_i = 1 with ch1 steady cnt=3, peak=3 -> ch1 leds = 0x04. Coincident strobe and tick: the display uses the old level and the new level appears at the next tick.
